alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_timer.sv | 46 ++++
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared ALU widths, opcode codes and sequencer state encodings
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PAR  = 2'b10;
  localparam logic [1:0] OP_COMP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BEAT_A    = 3'd1,
    S_BEAT_B    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_timer.sv
`default_nettype none
// ============================================================================
// alu_seq_timer : 4-bit WAIT_DONE cycle counter with expiry flag vs TIMEOUT
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [3:0] TIMER_LIMIT = 4'(TIMEOUT);

  if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_bad_timeout
    $error("alu_seq_timer: TIMEOUT must be in 2..15");
  end

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Clear loads 1 so the first waiting cycle is already counted.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 4'd1;
    end else if (enable_i && (count_q != TIMER_LIMIT)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == TIMER_LIMIT);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : command sequencer serialising operands and opcode into a 2-beat ALU
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_data_a,
  input  logic [DATA_WIDTH-1:0] cmd_data_b,
  output logic                  opcode_valid,
  output logic                  opcode,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_timeout
);

  state_e                state_q;
  logic                  op_hi_q;
  logic [DATA_WIDTH-1:0] data_b_q;
  logic                  opcode_valid_q;
  logic                  opcode_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_overflow_q;
  logic                  rsp_timeout_q;
  logic                  w_timer_expired;

  alu_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (state_q == S_BEAT_B),
    .enable_i  (state_q == S_WAIT_DONE),
    .expired_o (w_timer_expired)
  );

  // Beat outputs are loaded on the edge that enters each beat state, so they
  // line up with the state without any combinational path to the ALU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      op_hi_q        <= 1'b0;
      data_b_q       <= '0;
      opcode_valid_q <= 1'b0;
      opcode_q       <= 1'b0;
      data_q         <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_hi_q        <= cmd_opcode[1];
            data_b_q       <= cmd_data_b;
            opcode_valid_q <= 1'b1;
            opcode_q       <= cmd_opcode[0];
            data_q         <= cmd_data_a;
            state_q        <= S_BEAT_A;
          end
        end
        S_BEAT_A: begin
          opcode_q <= op_hi_q;
          data_q   <= data_b_q;
          state_q  <= S_BEAT_B;
        end
        S_BEAT_B: begin
          opcode_valid_q <= 1'b0;
          opcode_q       <= 1'b0;
          data_q         <= '0;
          state_q        <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // done wins over expiry on the final cycle.
          if (done) begin
            rsp_valid_q    <= 1'b1;
            rsp_result_q   <= result;
            rsp_overflow_q <= overflow;
            rsp_timeout_q  <= 1'b0;
            state_q        <= S_RESP;
          end else if (w_timer_expired) begin
            rsp_valid_q    <= 1'b1;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_timeout_q  <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          opcode_valid_q <= 1'b0;
          opcode_q       <= 1'b0;
          data_q         <= '0;
          rsp_valid_q    <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign opcode_valid = opcode_valid_q;
  assign opcode       = opcode_q;
  assign data         = data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : directed scoreboard bench for alu_seq with a 2-beat ALU model
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  import alu_pkg::*;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_opcode = 2'b00;
  logic [7:0] cmd_data_a = 8'h00;
  logic [7:0] cmd_data_b = 8'h00;
  logic       opcode_valid;
  logic       opcode;
  logic [7:0] data;
  logic       done;
  logic [7:0] m_result = 8'h00;
  logic       m_ovf = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_overflow;
  logic       rsp_timeout;
  logic       m_done = 1'b0;
  logic       spur_done = 1'b0;

  assign done = m_done | spur_done;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 0;
  int   viol = 0;
  int   alu_delay = 1;

  alu_seq #(
    .DATA_WIDTH (8),
    .TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opcode   (cmd_opcode),
    .cmd_data_a   (cmd_data_a),
    .cmd_data_b   (cmd_data_b),
    .opcode_valid (opcode_valid),
    .opcode       (opcode),
    .data         (data),
    .done         (done),
    .result       (m_result),
    .overflow     (m_ovf),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    exp_t       e;
    case (op)
      OP_ADD:  w = {1'b0, a} + {1'b0, b};
      OP_SUB:  w = {1'b0, a} - {1'b0, b};
      OP_PAR:  w = {1'b0, a ^ b};
      default: w = {1'b0, ~(a ^ b)};
    endcase
    e.res = w[7:0];
    e.ovf = w[8];
    e.to  = 1'b0;
    return e;
  endfunction

  // ALU model: rebuilds the command from the two beats, answers alu_delay cycles later.
  initial begin : alu_model
    logic [7:0] ma;
    logic       ma_op;
    bit         have_a;
    int         cnt;
    exp_t       r;
    have_a = 0;
    cnt    = 0;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (reset_n !== 1'b1) begin
        have_a = 0;
        cnt    = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) m_done = 1'b1;
        end
        if (opcode_valid === 1'b1) begin
          if (!have_a) begin
            ma     = data;
            ma_op  = opcode;
            have_a = 1;
          end else begin
            r        = ref_alu({opcode, ma_op}, ma, data);
            m_result = r.res;
            m_ovf    = r.ovf;
            have_a   = 0;
            cnt      = alu_delay;
          end
        end
      end
    end
  end

  initial begin : sb_monitor
    bit   seen;
    int   run;
    exp_t e;
    seen = 0;
    run  = 0;
    forever begin
      @(negedge clk);
      if (opcode_valid === 1'b1) begin
        run++;
        if (run > 2) viol++;
      end else begin
        run = 0;
        if (data !== 8'h00 || opcode !== 1'b0) viol++;
      end
      if (rsp_valid === 1'b1 && !seen) begin
        seen = 1;
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
      end
      if (rsp_valid !== 1'b1) seen = 0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Drives one command and checks both beats; returns on the beat-B negedge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input bit exp_to);
    exp_t e;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_data_a = a;
    cmd_data_b = b;
    if (exp_to) e = '{res: 8'h00, ovf: 1'b0, to: 1'b1};
    else        e = ref_alu(op, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    check("beat_a_valid", 32'(opcode_valid), 32'd1);
    check("beat_a_data", 32'(data), 32'(a));
    check("beat_a_op", 32'(opcode), 32'(op[0]));
    @(negedge clk);
    lat = 2;
    spur_done = 1'b0;
    check("beat_b_valid", 32'(opcode_valid), 32'd1);
    check("beat_b_data", 32'(data), 32'(b));
    check("beat_b_op", 32'(opcode), 32'(op[1]));
  endtask

  task automatic wait_rsp(input int max_cyc);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      lat++;
      n++;
    end
    check("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  initial begin : stimulus
    int hits;
    #2 reset_n = 1'b0;
    #1;
    check("rst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    rsp_ready = 1'b1;

    // ADD with carry out, done on first wait cycle: minimum latency.
    alu_delay = 1;
    send(OP_ADD, 8'hF0, 8'h20, 0);
    wait_rsp(20);
    check("add_latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("add_rsp_dropped", 32'(rsp_valid), 32'd0);

    // COMP with a stalled downstream.
    rsp_ready = 1'b0;
    send(OP_COMP, 8'h0F, 8'h0F, 0);
    wait_rsp(20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("comp_hold_valid", 32'(rsp_valid), 32'd1);
      check("comp_hold_result", 32'(rsp_result), 32'hFF);
      check("comp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("comp_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("comp_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // SUB that the ALU never answers.
    alu_delay = 0;
    send(OP_SUB, 8'h05, 8'h06, 1);
    wait_rsp(40);
    check("timeout_latency", 32'(lat), 32'(3 + TO));
    check("timeout_flag", 32'(rsp_timeout), 32'd1);
    check("timeout_result", 32'(rsp_result), 32'd0);
    @(negedge clk);

    // done arriving on the final allowed cycle is a success.
    alu_delay = TO;
    send(OP_ADD, 8'h01, 8'h02, 0);
    wait_rsp(40);
    check("late_done_latency", 32'(lat), 32'(3 + TO));
    check("late_done_no_timeout", 32'(rsp_timeout), 32'd0);
    @(negedge clk);

    // Reset asserted while in BEAT_B.
    alu_delay = 1;
    send(OP_ADD, 8'h11, 8'h22, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("midrst_data", 32'(data), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    sb_q.delete();
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) hits++;
    end
    check("midrst_no_response", 32'(hits), 32'd0);
    send(OP_PAR, 8'h0C, 8'h05, 0);
    wait_rsp(20);
    check("post_rst_latency", 32'(lat), 32'd4);
    @(negedge clk);

    // Spurious done in IDLE and BEAT_A.
    spur_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("spur_idle_rsp", 32'(rsp_valid), 32'd0);
      check("spur_idle_ready", 32'(cmd_ready), 32'd1);
    end
    send(OP_PAR, 8'h03, 8'h01, 0);
    wait_rsp(20);
    check("spur_latency", 32'(lat), 32'd4);
    check("spur_result", 32'(rsp_result), 32'h02);
    @(negedge clk);

    // Back-to-back with cmd_valid held high.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opcode = OP_ADD;
    cmd_data_a = 8'h10;
    cmd_data_b = 8'h20;
    sb_q.push_back(ref_alu(OP_ADD, 8'h10, 8'h20));
    @(negedge clk);
    check("b2b_first_beat", 32'(data), 32'h10);
    cmd_opcode = OP_SUB;
    cmd_data_a = 8'h30;
    cmd_data_b = 8'h10;
    sb_q.push_back(ref_alu(OP_SUB, 8'h30, 8'h10));
    lat = 1;
    wait_rsp(20);
    check("b2b_ready_in_resp", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("b2b_ready_after_hs", 32'(cmd_ready), 32'd1);
    check("b2b_no_beat_in_idle", 32'(opcode_valid), 32'd0);
    @(negedge clk);
    check("b2b_second_beat_valid", 32'(opcode_valid), 32'd1);
    check("b2b_second_beat_data", 32'(data), 32'h30);
    cmd_valid = 1'b0;
    wait_rsp(20);
    @(negedge clk);

    check("beat_window_violations", 32'(viol), 32'd0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
